instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter MEM_DEPTH, default 100: number of instruction words the memory holds; valid load addresses are 0..MEM_DEPTH-1.
REQ-002 Parameter ADDR_WIDTH, default 32: width of MemAddress; it matches the program-counter width.
REQ-003 Clock  in  1  single clock; all state updates on posedge Clock.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-006 WordCount  in  7  number of words to load; sampled on the accepted Start.
REQ-007 ByteData  in  8  incoming program byte.
REQ-008 ByteValid  in  1  ByteData is valid this cycle.
REQ-009 ByteReady  out  1  loader accepts a byte this cycle; a byte transfers when ByteValid and ByteReady are both 1.
REQ-010 MemWrite  out  1  one-cycle write strobe to instruction memory.
REQ-011 MemAddress  out  ADDR_WIDTH  word address for the write.
REQ-012 MemData  out  32  assembled instruction word.
REQ-013 Busy  out  1  load in progress; the CPU is held while this is 1.
REQ-014 Done  out  1  load finished; held at 1 until the next accepted Start or Reset.
REQ-015 Error  out  1  load failed; valid only while Done is 1.

Function
REQ-016 The FSM SHALL have states IDLE, RECV, WRITE, CHECK (only when LOADER_CHECKSUM_EN is defined) and DONE.
REQ-017 In IDLE or DONE, Start=1 SHALL clear Done, Error, the address counter and the byte counter, latch WordCount, and move the FSM to RECV.
REQ-018 If the latched WordCount is 0 or greater than MEM_DEPTH, the FSM SHALL go to DONE with Error=1, and no write or byte acceptance SHALL occur.
REQ-019 In RECV, ByteReady SHALL be 1, and each transfer SHALL shift the byte into a 32-bit assembly register, first byte into bits 31:24 (big-endian).
REQ-020 After the 4th byte of a word transfers, the FSM SHALL move to WRITE, where ByteReady is 0.
REQ-021 In WRITE, for exactly one cycle, MemWrite SHALL be 1 with MemAddress = address counter and MemData = assembled word; the address counter then increments.
REQ-022 After WRITE, the FSM SHALL return to RECV if words remain, else go to CHECK (macro defined) or DONE (macro undefined).
REQ-023 Latency: MemWrite SHALL assert in the cycle after the 4th byte transfers.
REQ-024 Busy SHALL be 1 in RECV, WRITE and CHECK, and 0 in IDLE and DONE.
REQ-025 Start SHALL be ignored while Busy=1.
REQ-026 ByteValid=0 in RECV SHALL stall the FSM with no state change, and partial byte count SHALL be retained.
REQ-027 The address counter SHALL never exceed MEM_DEPTH-1 on a write, and there is no wrap-around.
REQ-028 With Start=1 and Done=1 in the same cycle, Done SHALL clear and a new load begin.

Reset
REQ-029 Reset SHALL force IDLE, and SHALL drive ByteReady=0, MemWrite=0, MemAddress=0, MemData=0, Busy=0, Done=0 and Error=0.
REQ-030 Reset mid-load SHALL discard the partial word without issuing a write, and words already written SHALL remain in memory.

Configuration
REQ-031 When macro LOADER_CHECKSUM_EN is defined, CHECK SHALL accept 4 further bytes as a big-endian checksum.
REQ-032 With the macro defined, the accumulator SHALL be the sum mod 2^32 of all written words; DONE is entered with Error=1 if the checksum does not match it, else Error=0.
REQ-033 When the macro is undefined, the CHECK state and accumulator SHALL be absent, and Error SHALL indicate only an invalid WordCount.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the MEM_DEPTH default, and the instruction width constant 32.
REQ-035 One sub-module, byte_assembler, SHALL hold the shift register and 2-bit byte counter, with a word_ready output.

Verification
REQ-036 Test 1: WordCount=3, bytes 2C 0E 00 00 / 51 CF 00 05 / 31 E0 00 00 -> writes 0x2C0E0000@0, 0x51CF0005@1, 0x31E00000@2; then Done=1, Error=0.
REQ-037 Test 2: WordCount=0 -> Done=1, Error=1 within 2 cycles, with no MemWrite and ByteReady never 1.
REQ-038 Test 3: WordCount=2, with ByteValid dropped for 5 cycles after the 2nd byte -> words are still correct and no extra MemWrite occurs.
REQ-039 Test 4: Reset asserted after 6 bytes of a 2-word load -> exactly 1 write; then IDLE with all outputs 0.
REQ-040 Test 5 (macro defined): words 0x00000001 and 0xFFFFFFFF with checksum 0x00000000 -> Error=0; the same words with checksum 0x00000001 -> Error=1.
REQ-041 Test 6: Start pulsed while Busy=1 -> ignored; the load completes with the original WordCount.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the serial instruction loader.
// The CHECK state only exists when LOADER_CHECKSUM_EN is defined.
package instruction_loader_pkg;

  localparam int MEM_DEPTH_DEF = 100;
  localparam int INSTR_W       = 32;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_e;

endpackage

// File: rtl/instruction_loader_byte_asm.sv
// byte_assembler: packs four bytes big-endian into one instruction word.
// word_ready_o flags the cycle in which the fourth byte is being shifted in.
module byte_assembler
  import instruction_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_ready_o
);

  logic [INSTR_W-1:0] word_q;
  logic [1:0]         cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_i) begin
      word_q <= {word_q[INSTR_W-9:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Streams bytes into 32-bit words and writes them to instruction memory.
// Define LOADER_CHECKSUM_EN to append a 4-byte sum check after the last word.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [6:0]            WordCount,
  input  logic [7:0]            ByteData,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [INSTR_W-1:0]    MemData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [6:0]            left_q, left_d;
  logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0]    acc_q, acc_d;
`endif

  logic               idle_like, start_ok, wc_bad, xfer, word_ready;
  logic [INSTR_W-1:0] word;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign start_ok  = Start && idle_like;
  assign wc_bad    = (WordCount == 7'd0) || (32'(WordCount) > MEM_DEPTH);
  assign xfer      = ByteValid && ByteReady;

  byte_assembler u_asm (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .clr_i       (start_ok),
    .shift_i     (xfer),
    .byte_i      (ByteData),
    .word_o      (word),
    .word_ready_o(word_ready)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          // An out-of-range count ends the load immediately, with no transfers.
          err_d   = wc_bad;
          addr_d  = '0;
          left_d  = WordCount;
`ifdef LOADER_CHECKSUM_EN
          acc_d   = '0;
`endif
          state_d = wc_bad ? DONE : RECV;
        end
      end
      RECV: if (word_ready) state_d = WRITE;
      WRITE: begin
        addr_d = addr_q + ADDR_ONE;
        left_d = left_q - 7'd1;
`ifdef LOADER_CHECKSUM_EN
        acc_d   = acc_q + word;
        state_d = (left_q == 7'd1) ? CHECK : RECV;
`else
        state_d = (left_q == 7'd1) ? DONE : RECV;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (word_ready) begin
          err_d   = ({word[INSTR_W-9:0], ByteData} != acc_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign ByteReady = (state_q == RECV) || (state_q == CHECK);
`else
  assign ByteReady = (state_q == RECV);
`endif
  // Address/data are forced to zero outside the write strobe.
  assign MemWrite   = (state_q == WRITE);
  assign MemAddress = MemWrite ? addr_q : '0;
  assign MemData    = MemWrite ? word : '0;
  assign Busy       = !idle_like;
  assign Done       = (state_q == DONE);
  assign Error      = Done && err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader against a queue-based model.
module tb_instruction_loader;

  localparam int DEPTH = 100;
  localparam int AW    = 32;

  logic          Clock = 1'b0;
  logic          Reset, Start, ByteValid;
  logic [6:0]    WordCount;
  logic [7:0]    ByteData;
  logic          ByteReady, MemWrite, Busy, Done, Error;
  logic [AW-1:0] MemAddress;
  logic [31:0]   MemData;

  instruction_loader #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .WordCount(WordCount),
    .ByteData(ByteData), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .MemWrite(MemWrite), .MemAddress(MemAddress), .MemData(MemData),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge Clock) cyc++;

  logic [31:0] wr_addr[$], wr_data[$];
  int          wr_cyc[$], exp_cyc[$];
  int          rdy_seen;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (MemWrite) begin
        wr_addr.push_back(MemAddress);
        wr_data.push_back(MemData);
        wr_cyc.push_back(cyc);
      end
      if (ByteReady) rdy_seen++;
    end
  end

  logic [31:0] wbuf [128];
  bit          cks_custom = 1'b0;
  logic [31:0] cks_val = '0;

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = $urandom;
  endtask

  // mode: 0 = always valid, 1 = random gaps, 2 = 5-cycle gap after the 2nd byte.
  // stop_after >= 0 abandons the load after that many bytes (no completion checks).
  task automatic run_load(input int n, input int mode, input bit bump, input string name,
                          input int stop_after);
    logic [7:0]  bq[$];
    logic [31:0] sum;
    bit          bad, exp_err, v;
    int          idx, budget, stalls;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); exp_cyc.delete();
    rdy_seen = 0;
    bad = (n == 0) || (n > DEPTH);
    sum = '0;
    exp_err = bad;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        bq.push_back(wbuf[i][31:24]); bq.push_back(wbuf[i][23:16]);
        bq.push_back(wbuf[i][15:8]);  bq.push_back(wbuf[i][7:0]);
        sum += wbuf[i];
      end
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [31:0] c;
        c = cks_custom ? cks_val : sum;
        bq.push_back(c[31:24]); bq.push_back(c[23:16]);
        bq.push_back(c[15:8]);  bq.push_back(c[7:0]);
        exp_err = (c != sum);
      end
`endif
    end
    @(negedge Clock);
    Start = 1'b1; WordCount = n[6:0];
    @(negedge Clock);
    Start = 1'b0;
    idx = 0; budget = 0; stalls = 0;
    while (idx < bq.size() && budget < 5000 && !(stop_after >= 0 && idx >= stop_after)) begin
      if (mode == 2 && idx == 2 && stalls < 5) begin v = 1'b0; stalls++; end
      else if (mode == 1) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      if (bump && idx == 5) begin
        chk({name, " busy_at_bump"}, 32'(Busy), 1);
        Start = 1'b1; WordCount = 7'($urandom_range(1, 7));
      end else Start = 1'b0;
      ByteValid = v;
      ByteData  = v ? bq[idx] : 8'($urandom);
      if (ByteReady && v) begin
        if (idx % 4 == 3 && idx < 4 * n) exp_cyc.push_back(cyc + 1);
        idx++;
      end
      budget++;
      @(negedge Clock);
    end
    ByteValid = 1'b0; Start = 1'b0;
    if (stop_after < 0) begin
      chk({name, " bytes_budget"}, 32'(budget < 5000), 1);
      budget = 0;
      while (!Done && budget < 20) begin @(negedge Clock); budget++; end
      if (bad) begin
        chk({name, " bad_latency"}, 32'(budget <= 1), 1);
        chk({name, " ready_never"}, rdy_seen, 0);
      end
      repeat (2) @(negedge Clock);
      chk({name, " done"}, 32'(Done), 1);
      chk({name, " error"}, 32'(Error), 32'(exp_err));
      chk({name, " busy"}, 32'(Busy), 0);
      chk({name, " nwrites"}, wr_addr.size(), bad ? 0 : n);
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
        chk($sformatf("%s addr%0d", name, i), wr_addr[i], i);
        chk($sformatf("%s data%0d", name, i), wr_data[i], wbuf[i]);
        if (i < exp_cyc.size())
          chk($sformatf("%s lat%0d", name, i), wr_cyc[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " ByteReady"}, 32'(ByteReady), 0);
    chk({name, " MemWrite"}, 32'(MemWrite), 0);
    chk({name, " MemAddress"}, MemAddress, 0);
    chk({name, " MemData"}, MemData, 0);
    chk({name, " Busy"}, 32'(Busy), 0);
    chk({name, " Done"}, 32'(Done), 0);
    chk({name, " Error"}, 32'(Error), 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; WordCount = '0; ByteValid = 1'b0; ByteData = '0;
    repeat (2) @(negedge Clock);
    chk_all_zero("in_reset");
    Reset = 1'b0;
    @(negedge Clock);
    chk_all_zero("post_reset");

    wbuf[0] = 32'h2C0E0000; wbuf[1] = 32'h51CF0005; wbuf[2] = 32'h31E00000;
    run_load(3, 0, 1'b0, "t1", -1);

    run_load(0, 0, 1'b0, "t2_zero", -1);
    run_load(DEPTH + 1, 0, 1'b0, "t2_over", -1);
    run_load(127, 0, 1'b0, "t2_max", -1);

    fill_random(2);
    run_load(2, 2, 1'b0, "t3", -1);

    fill_random(2);
    run_load(2, 0, 1'b0, "t4", 6);
    Reset = 1'b1;
    @(negedge Clock);
    chk_all_zero("t4_in_reset");
    Reset = 1'b0;
    @(negedge Clock);
    chk_all_zero("t4_idle");
    chk("t4 nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      chk("t4 addr0", wr_addr[0], 0);
      chk("t4 data0", wr_data[0], wbuf[0]);
    end

    fill_random(3);
    run_load(3, 1, 1'b1, "t6", -1);

`ifdef LOADER_CHECKSUM_EN
    wbuf[0] = 32'h00000001; wbuf[1] = 32'hFFFFFFFF;
    cks_custom = 1'b1; cks_val = 32'h00000000;
    run_load(2, 0, 1'b0, "t5_good", -1);
    cks_val = 32'h00000001;
    run_load(2, 1, 1'b0, "t5_bad", -1);
    cks_custom = 1'b0;
`endif

    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(n);
      run_load(n, 1, 1'b0, $sformatf("rnd%0d", k), -1);
    end

    fill_random(1);
    run_load(1, 0, 1'b0, "one", -1);
    fill_random(DEPTH);
    run_load(DEPTH, 1, 1'b0, "full", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
